// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converter.
//   BIN_W   : binary operand width (only 14 is supported)
//   DIGITS  : number of packed BCD digits produced
//   BCD_MAX : largest operand that fits in DIGITS decimal digits
//   ITERS   : double-dabble iterations, one per operand bit
package bcd_pkg;

    localparam int unsigned BIN_W   = 14;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned BCD_MAX = 9999;
    localparam int unsigned ITERS   = 14;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   din  : 4-bit digit before correction
//   dout : 4-bit corrected digit
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd4.sv
// Sequential double-dabble converter: 14-bit unsigned binary to 4 packed BCD
// digits, one iteration per clock, 14 cycles from accepting edge to done.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst   : synchronous active-high reset
//   start : conversion request, sampled only while idle
//   bin   : binary operand, captured on the accepting edge
//   busy  : high while shifting and during the done cycle
//   done  : one-cycle pulse, bcd/err valid from this cycle on
//   bcd   : packed BCD result, thousands digit in [15:12]
//   err   : captured operand was above 9999
// Build option:
//   BIN_TO_BCD4_SAT_EN : out-of-range operands report 16'h9999 instead of 16'h0000
module bin_to_bcd4 #(
    parameter int unsigned BIN_W = bcd_pkg::BIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd,
    output logic             err
);

    import bcd_pkg::*;

`ifdef BIN_TO_BCD4_SAT_EN
    localparam logic [15:0] OvfBcd = 16'h9999;
`else
    localparam logic [15:0] OvfBcd = 16'h0000;
`endif

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [15:0]      scratch_q, scratch_d;
    logic [BIN_W-1:0] op_q, op_d;
    logic             err_pend_q, err_pend_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             err_q, err_d;

    // Corrected scratch digits for the current iteration.
    logic [15:0]      corr;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (scratch_q[4*g +: 4]),
            .dout (corr[4*g +: 4])
        );
    end

    // Top bit shifts out; it is always zero for in-range operands and the
    // result is overridden for out-of-range ones.
    logic unused_corr_msb;
    assign unused_corr_msb = corr[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            scratch_q  <= 16'h0000;
            op_q       <= '0;
            err_pend_q <= 1'b0;
            bcd_q      <= 16'h0000;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            op_q       <= op_d;
            err_pend_q <= err_pend_d;
            bcd_q      <= bcd_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        op_d       = op_q;
        err_pend_d = err_pend_q;
        bcd_d      = bcd_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StShift;
                    op_d       = bin;
                    cnt_d      = 4'd0;
                    scratch_d  = 16'h0000;
                    err_pend_d = (bin > BIN_W'(BCD_MAX));
                end
            end
            StShift: begin
                scratch_d = {corr[14:0], op_q[BIN_W-1]};
                op_d      = op_q << 1;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'(ITERS - 1)) begin
                    state_d = StDone;
                    bcd_d   = err_pend_q ? OvfBcd : scratch_d;
                    err_d   = err_pend_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign bcd  = bcd_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Directed self-checking bench for bin_to_bcd4.
// Honours BIN_TO_BCD4_SAT_EN for the expected out-of-range result.
module tb_bin_to_bcd4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

`ifdef BIN_TO_BCD4_SAT_EN
    localparam logic [15:0] ExpOvf = 16'h9999;
`else
    localparam logic [15:0] ExpOvf = 16'h0000;
`endif

    bin_to_bcd4 #(.BIN_W(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream divisibility-by-11 checker: alternating digit sum.
    function automatic logic div11(input logic [15:0] v);
        int s;
        s = int'(v[3:0]) - int'(v[7:4]) + int'(v[11:8]) - int'(v[15:12]);
        return (s % 11) == 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one conversion and check latency, result, and done pulse width.
    // Called and returns at posedge+1.
    task automatic convert(input string tag, input logic [13:0] val,
                           input logic [15:0] exp_bcd, input logic exp_err);
        int lat;
        lat   = 0;
        start = 1'b1;
        bin   = val;
        step();
        start = 1'b0;
        bin   = '0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 30; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, "_latency"}, lat, 14);
        check_eq({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        step();
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        check_eq({tag, "_bcd_hold"}, 32'(bcd), 32'(exp_bcd));
    endtask

    initial begin
        int ndone;
        int first;
        int t1;
        int t2;
        logic [15:0] b1;
        logic [15:0] b2;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) step();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_bcd", 32'(bcd), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();

        convert("zero", 14'd0, 16'h0000, 1'b0);
        convert("b11", 14'd11, 16'h0011, 1'b0);
        check_eq("b11_div11", 32'(div11(bcd)), 32'd1);
        convert("b9097", 14'd9097, 16'h9097, 1'b0);
        check_eq("b9097_div11", 32'(div11(bcd)), 32'd1);
        convert("b9999", 14'd9999, 16'h9999, 1'b0);
        convert("b12345", 14'd12345, ExpOvf, 1'b1);
        convert("b10000", 14'd10000, ExpOvf, 1'b1);
        convert("b5678", 14'd5678, 16'h5678, 1'b0);

        // Second start during SHIFT must be ignored.
        start = 1'b1;
        bin   = 14'd9090;
        step();
        start = 1'b0;
        ndone = 0;
        first = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 5) begin
                start = 1'b1;
                bin   = 14'd22;
            end else if (i == 6) begin
                start = 1'b0;
                bin   = '0;
            end
            step();
            if (done) begin
                ndone++;
                if (first == 0) first = i;
            end
        end
        check_eq("ign_ndone", ndone, 1);
        check_eq("ign_latency", first, 14);
        check_eq("ign_bcd", 32'(bcd), 32'h9090);

        // Reset mid-conversion discards the operand.
        start = 1'b1;
        bin   = 14'd4321;
        step();
        start = 1'b0;
        bin   = '0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_bcd", 32'(bcd), 32'd0);
        check_eq("midrst_err", 32'(err), 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) ndone++;
        end
        check_eq("midrst_nodone", ndone, 0);
        convert("after_rst", 14'd22, 16'h0022, 1'b0);

        // Reset has priority over start.
        rst   = 1'b1;
        start = 1'b1;
        bin   = 14'd77;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check_eq("rst_prio_busy", 32'(busy), 32'd0);

        // Back-to-back with start held high.
        step();
        start = 1'b1;
        bin   = 14'd17;
        step();
        bin = 14'd902;
        t1  = 0;
        t2  = 0;
        b1  = '0;
        b2  = '0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin
                if (t1 == 0) begin
                    t1 = i;
                    b1 = bcd;
                end else if (t2 == 0) begin
                    t2 = i;
                    b2 = bcd;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_eq("b2b_first_lat", t1, 14);
        check_eq("b2b_spacing", t2 - t1, 16);
        check_eq("b2b_bcd1", 32'(b1), 32'h0017);
        check_eq("b2b_bcd2", 32'(b2), 32'h0902);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd4.md
BIN_TO_BCD4 -- requirements
Module: bin_to_bcd4

Interface
REQ-001: Parameter BIN_W, default 14, SHALL set the binary input width; values other than 14 are unsupported.
REQ-002: Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: Port rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004: Port start  input  1  SHALL request a conversion; sampled only in IDLE.
REQ-005: Port bin  input  BIN_W  SHALL carry the unsigned binary operand, captured on the accepting edge.
REQ-006: Port busy  output  1  SHALL be high in SHIFT and DONE.
REQ-007: Port done  output  1  SHALL be a one-cycle pulse marking valid bcd/err.
REQ-008: Port bcd  output  16  SHALL carry 4 packed BCD digits, thousands in [15:12], matching the downstream divisibility checker's input format.
REQ-009: Port err  output  1  SHALL flag that the captured operand exceeded 9999.

Function
REQ-010: FSM SHALL have states IDLE, SHIFT, DONE.
REQ-011: IDLE->SHIFT on an edge with start=1: latch bin, clear the 4-bit iteration counter and 16-bit scratch, latch err_next=(bin>9999).
REQ-012: In SHIFT, each edge SHALL perform one double-dabble iteration: add 3 to every scratch digit >=5, then shift {scratch,operand} left 1.
REQ-013: After the 14th iteration (edge k+14, k = accepting edge), state SHALL become DONE, bcd and err SHALL be updated and done=1 during that cycle.
REQ-014: DONE->IDLE SHALL occur unconditionally on the next edge; done returns to 0.
REQ-015: Latency SHALL be 14 cycles from accepting edge to done; with start held high, throughput SHALL be one result per 16 cycles.
REQ-016: start in SHIFT or DONE SHALL be ignored; no queuing.
REQ-017: bcd and err SHALL hold their last values until the next DONE.
REQ-018: If the operand exceeds 9999, timing SHALL be unchanged; the bcd value follows REQ-022/023.
REQ-019: Digit correction SHALL never produce a digit above 9 for operands <=9999.

Reset
REQ-020: rst=1 at any edge SHALL force IDLE, busy=0, done=0, bcd=16'h0000, err=0, counter=0.
REQ-021: rst mid-conversion SHALL discard the in-flight operand with no done pulse; rst has priority over start.

Configuration
REQ-022: With BIN_TO_BCD4_SAT_EN defined, an out-of-range operand SHALL yield bcd=16'h9999, err=1.
REQ-023: Without BIN_TO_BCD4_SAT_EN, an out-of-range operand SHALL yield bcd=16'h0000, err=1.

Structure
REQ-024: Package bcd_pkg SHALL hold BIN_W=14, DIGITS=4, BCD_MAX=9999, ITERS=14, and the FSM state enum.
REQ-025: Sub-module bcd_add3 (4-bit in, 4-bit out, add 3 if >=5) SHALL be instantiated once per digit.

Verification
REQ-026: bin=0, start pulse -> done at +14 cycles, bcd=16'h0000, err=0.
REQ-027: bin=11 -> bcd=16'h0011; bin=9097 -> 16'h9097; bin=9999 -> 16'h9999; err=0; chained checker reports divisible=1 for 11 and 9097.
REQ-028: bin=12345 -> err=1; bcd=16'h0000 without the macro, 16'h9999 with it.
REQ-029: start bin=9090, second start bin=22 at +5 cycles -> single done at +14, bcd=16'h9090; 22 not converted.
REQ-030: start bin=4321, rst high at +7 cycles -> no done, all outputs zero; then start bin=22 -> bcd=16'h0022 at +14.
REQ-031: start held high, bins 17 then 902 -> done pulses 16 cycles apart, bcd=16'h0017 then 16'h0902.
